sobel_window_writer: RTL
========================

// Module: sobel_window_writer
// PURPOSE
//   Consumer end of the 3x3 window interface driven by top_module_imp (out1..out9).
//   Accepts one 3x3 pixel window per handshake and computes the Sobel magnitude
//   |Gx|+|Gy|, saturated to 8 bits. Writes the result sequentially into the output
//   image RAM (linear address 0..IMG_W*IMG_H-1), then pulses frame_done.
// PARAMETERS
//   IMG_W   128  output image width, in pixels
//   IMG_H   128  output image height, in pixels
//   ADDR_W  14   mem_addr width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// PORTS
//   CLK         in   1       system clock; all logic on the rising edge
//   RST         in   1       synchronous, active-high reset
//   start       in   1       one-cycle pulse; begins a frame (honoured only in IDLE)
//   win1..win9  in   8 each  window pixels, row-major; win1 = top-left, win5 = centre, win9 = bottom-right
//   win_valid   in   1       window present on win1..win9
//   win_ready   out  1       block accepts a window this cycle
//   mem_we      out  1       write strobe to the output RAM
//   mem_addr    out  ADDR_W  write address
//   mem_data    out  8       Sobel magnitude
//   busy        out  1       high in RUN and FLUSH
//   frame_done  out  1       one-cycle pulse at the end of a frame
// BEHAVIOUR
// - Reset: all outputs 0, FSM = IDLE, pixel counter = 0, pipeline valid bits cleared.
//   - Reset mid-frame aborts the frame. No further mem_we is issued for in-flight windows.
// - Accept: a window is accepted when win_valid && win_ready at a rising edge.
// - FSM states:
//   - IDLE: win_ready = 0. On start, go to RUN and clear the counter.
//   - RUN: win_ready = 1.
//     - Each accept increments the counter.
//     - The accept with counter == IMG_W*IMG_H-1 goes to FLUSH.
//     - start is ignored.
//   - FLUSH: win_ready = 0. Wait until both pipeline stages are empty, then go to DONE.
//   - DONE: frame_done = 1 for exactly one cycle, then go to IDLE.
//     - busy = 0; win_ready = 0.
//     - start during DONE is ignored.
// - Arithmetic, pipeline stage 1 (registered, signed 11-bit):
//   - Gx = (win3 + 2*win6 + win9) - (win1 + 2*win4 + win7)
//   - Gy = (win7 + 2*win8 + win9) - (win1 + 2*win2 + win3)
//   - Range is +/-1020; no overflow in 11 bits.
// - Arithmetic, pipeline stage 2 (registered):
//   - m = |Gx| + |Gy|, unsigned 11-bit, maximum 2040.
//   - mem_data = (m > 255) ? 255 : m[7:0].
// - Latency: mem_we/mem_addr/mem_data are valid exactly 2 cycles after the accepting edge.
//   - mem_we is high for 1 cycle per accepted window.
//   - mem_addr = counter value at accept time.
// - Stalls: when win_valid = 0 in RUN, no accept occurs and the counter holds.
//   - The pipeline still advances (bubbles); mem_we = 0 for bubbles.
// - Ordering: frame_done rises on the cycle after the final mem_we pulse.
//   - No mem_we occurs in DONE or IDLE.
// - Outputs when mem_we = 0:
//   - mem_addr and mem_data hold their last written values.
//   - After reset they read 0.
// - Counter wrap: the counter never exceeds IMG_W*IMG_H-1. It returns to 0 only on start or RST.
// TESTING
// 1. Flat window (all pixels 100), single accept at cycle N -> mem_we high at N+2, mem_addr 0, mem_data 0.
// 2. win3 = win6 = win9 = 10, all others 0 -> Gx = 40, Gy = 0, mem_data 40.
//    Left column 0, right column 255 -> mem_data 255 (saturated).
// 3. IMG_W = 4, IMG_H = 2, start, then 8 back-to-back windows:
//    - mem_addr goes 0..7 on consecutive cycles.
//    - win_ready drops the cycle after the 8th accept.
//    - frame_done pulses once, 1 cycle after the last mem_we.
// 4. win_valid toggling 1,0,0,1 in RUN -> exactly 2 mem_we pulses, at addresses 0 and 1; counter holds during gaps.
// 5. RST asserted after 3 accepts ->
//    - next cycle: all outputs 0, no mem_we for in-flight windows;
//    - a new start writes from address 0.
// 6. start pulsed during RUN or DONE -> ignored; addresses continue unchanged; frame_done fires only once.

Source files
------------

// File: rtl/sobel_window_writer.sv
// sobel_window_writer: accepts 3x3 windows, computes saturated |Gx|+|Gy|,
// and writes one result per window into the output image RAM in raster order.
module sobel_window_writer #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        win1,
    input  logic [7:0]        win2,
    input  logic [7:0]        win3,
    input  logic [7:0]        win4,
    input  logic [7:0]        win5,
    input  logic [7:0]        win6,
    input  logic [7:0]        win7,
    input  logic [7:0]        win8,
    input  logic [7:0]        win9,
    input  logic              win_valid,
    output logic              win_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              frame_done
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic [ADDR_W-1:0]  addr1_q;
    logic               v1_q;
    logic signed [10:0] gx_q, gy_q;
    logic signed [10:0] gx_d, gy_d;
    logic [10:0]        xr, xl, yb, yt, ax, ay, m;
    logic [7:0]         data_d;
    logic               accept;

    assign accept = win_valid && win_ready;

    // Column/row sums are non-negative and fit in 10 bits, so 11-bit wrap-around
    // subtraction yields the exact two's-complement gradient.
    always_comb begin
        xr     = 11'(win3) + 11'({win6, 1'b0}) + 11'(win9);
        xl     = 11'(win1) + 11'({win4, 1'b0}) + 11'(win7);
        yb     = 11'(win7) + 11'({win8, 1'b0}) + 11'(win9);
        yt     = 11'(win1) + 11'({win2, 1'b0}) + 11'(win3);
        gx_d   = xr - xl;
        gy_d   = yb - yt;
        ax     = gx_q[10] ? -gx_q : gx_q;
        ay     = gy_q[10] ? -gy_q : gy_q;
        m      = ax + ay;
        data_d = (m > 11'd255) ? 8'hFF : m[7:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q     <= 1'b0;
            gx_q     <= '0;
            gy_q     <= '0;
            addr1_q  <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            v1_q   <= accept;
            mem_we <= v1_q;
            if (accept) begin
                gx_q    <= gx_d;
                gy_q    <= gy_d;
                addr1_q <= cnt_q;
            end
            if (v1_q) begin
                mem_addr <= addr1_q;
                mem_data <= data_d;
            end
        end
    end

    // Leaving FLUSH once stage 1 is empty lets the last write drain in the same
    // cycle, so frame_done lands directly after the final mem_we pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            win_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q   <= RUN;
                    cnt_q     <= '0;
                    win_ready <= 1'b1;
                    busy      <= 1'b1;
                end
                RUN: if (accept) begin
                    if (cnt_q == LAST) begin
                        state_q   <= FLUSH;
                        win_ready <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                FLUSH: if (!v1_q) begin
                    state_q    <= DONE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end
endmodule
